// File: rtl/packetcheck.sv
// packetcheck: AXI-stream frame checker (header magic, flow/sequence, payload pattern)
// Ports: clk, rst_n, s_axis_* sink, cnt_clr; frame_done/frame_err/err_sticky + stats counters.
// Optional macro PACKETCHECK_PAYLOAD_CHECK_EN builds the payload pattern comparators (frame_err[4]).
module packetcheck #(
  parameter int DATA_WIDTH = 64,
  parameter int N_FLOWS    = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic                    cnt_clr,
  output logic                    frame_done,
  output logic [5:0]              frame_err,
  output logic [5:0]              err_sticky,
  output logic [CNT_WIDTH-1:0]    good_frames,
  output logic [CNT_WIDTH-1:0]    bad_frames,
  output logic [CNT_WIDTH-1:0]    seq_errors,
  output logic [CNT_WIDTH-1:0]    rx_bytes
);

  typedef enum logic {HDR, BODY} state_e;

  state_e                 state_q;
  logic [4:0]             beat_q;
  logic [5:0]             err_acc_q;
  logic [5:0]             err_d;
  logic [5:0]             beat_err;
  logic                   done_q;
  logic [5:0]             ferr_q;
  logic [5:0]             sticky_q;
  logic [CNT_WIDTH-1:0]   good_q, bad_q, seqe_q, rxb_q;
  logic [N_FLOWS-1:0]     sync_q;
  logic [31:0]            exp_q [N_FLOWS];

  logic        acc;
  logic        magic_ok;
  logic        flow_ok;
  logic        f_sync;
  logic [31:0] f_exp;
  logic [7:0]  hdr_flow;
  logic [31:0] hdr_seq;
  logic        upd_flow;
  logic [7:0]  keep_inc;
  logic        contig;
  logic        pay_err;
  logic [3:0]  pop;
  logic [CNT_WIDTH:0] rx_sum;
  logic        unused_bits;

  assign s_axis_tready = rst_n;
  assign acc      = s_axis_tvalid & s_axis_tready;
  assign magic_ok = s_axis_tdata[63:48] == 16'hA5C3;
  assign hdr_flow = s_axis_tdata[47:40];
  assign hdr_seq  = s_axis_tdata[31:0];
  assign upd_flow = acc & (state_q == HDR) & magic_ok & flow_ok;

  always_comb begin
    flow_ok = 1'b0;
    f_sync  = 1'b0;
    f_exp   = '0;
    for (int f = 0; f < N_FLOWS; f++) begin
      if (hdr_flow == 8'(f)) begin
        flow_ok = 1'b1;
        f_sync  = sync_q[f];
        f_exp   = exp_q[f];
      end
    end
  end

  // Contiguous last-beat keep is 2^n-1 with n>=1.
  assign keep_inc = s_axis_tkeep + 8'd1;
  assign contig   = (|s_axis_tkeep) & ~(|(keep_inc & s_axis_tkeep));

`ifdef PACKETCHECK_PAYLOAD_CHECK_EN
  // Byte i of beat k carries 8k+i mod 256; beat_q wraps at 32.
  always_comb begin
    pay_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s_axis_tkeep[i] &&
          s_axis_tdata[8*i +: 8] != {beat_q, 3'(i)})
        pay_err = 1'b1;
    end
  end
  assign unused_bits = ^s_axis_tdata[39:32];
`else
  assign pay_err     = 1'b0;
  assign unused_bits = ^{s_axis_tdata[39:32], beat_q};
`endif

  always_comb begin
    beat_err    = '0;
    beat_err[0] = s_axis_tlast & s_axis_tuser;
    if (state_q == HDR) begin
      beat_err[1] = ~magic_ok;
      beat_err[2] = ~flow_ok;
      beat_err[3] = magic_ok & flow_ok & f_sync & (hdr_seq != f_exp);
      beat_err[5] = s_axis_tlast | (s_axis_tkeep != 8'hFF);
    end else begin
      beat_err[4] = pay_err;
      beat_err[5] = s_axis_tlast ? ~contig : (s_axis_tkeep != 8'hFF);
    end
  end

  assign err_d = ((state_q == HDR) ? 6'd0 : err_acc_q) | beat_err;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) pop = pop + 4'(s_axis_tkeep[i]);
  end

  assign rx_sum = {1'b0, rxb_q} + (CNT_WIDTH+1)'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HDR;
      beat_q    <= '0;
      err_acc_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (acc) begin
        if (s_axis_tlast) begin
          state_q   <= HDR;
          beat_q    <= '0;
          err_acc_q <= '0;
          done_q    <= 1'b1;
          ferr_q    <= err_d;
        end else begin
          state_q   <= BODY;
          beat_q    <= beat_q + 5'd1;
          err_acc_q <= err_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      for (int f = 0; f < N_FLOWS; f++) exp_q[f] <= '0;
    end else if (upd_flow) begin
      for (int f = 0; f < N_FLOWS; f++) begin
        if (hdr_flow == 8'(f)) begin
          sync_q[f] <= 1'b1;
          exp_q[f]  <= hdr_seq + 32'd1;
        end
      end
    end
  end

  // Frame statistics follow frame_done by one edge so a clear
  // in the frame_done cycle drops that frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q   <= '0;
      bad_q    <= '0;
      seqe_q   <= '0;
      rxb_q    <= '0;
      sticky_q <= '0;
    end else if (cnt_clr) begin
      good_q   <= '0;
      bad_q    <= '0;
      seqe_q   <= '0;
      rxb_q    <= '0;
      sticky_q <= '0;
    end else begin
      if (acc)
        rxb_q <= rx_sum[CNT_WIDTH] ? '1 : rx_sum[CNT_WIDTH-1:0];
      if (done_q) begin
        sticky_q <= sticky_q | ferr_q;
        if (ferr_q == 6'd0) begin
          if (good_q != '1) good_q <= good_q + 1'b1;
        end else begin
          if (bad_q != '1) bad_q <= bad_q + 1'b1;
        end
        if (ferr_q[3] && seqe_q != '1) seqe_q <= seqe_q + 1'b1;
      end
    end
  end

  assign frame_done  = done_q;
  assign frame_err   = ferr_q;
  assign err_sticky  = sticky_q;
  assign good_frames = good_q;
  assign bad_frames  = bad_q;
  assign seq_errors  = seqe_q;
  assign rx_bytes    = rxb_q;

endmodule
